// File: rtl/catalog_pkg.sv
// Shared helpers for catalog buffering elements.
// Pointer sizing for wrap-bit FIFOs.
package catalog_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Valid/ready handshake bundle for fifo_sync.
// master drives producer/consumer side, slave is the FIFO.
interface fifo_sync_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH flop array.
// One synchronous write port, one async read port.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO with valid/ready on both sides.
// Wrap-bit pointers distinguish full from empty.
module fifo_sync
  import catalog_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  fifo_sync_if.slave               bus,
  output logic [ptr_w(DEPTH)-1:0]  count,
  output logic                     almost_full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  typedef logic [PW-1:0] fptr_t;

  fptr_t rd_ptr;
  fptr_t wr_ptr;
  fptr_t count_n;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] rdata;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0])
              && (rd_ptr[AW] != wr_ptr[AW]);

  assign push = bus.in_valid & ~full;
  assign pop  = ~empty & bus.out_ready;

  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : rdata;

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else if (clr) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_n;
      almost_full <= (count_n >= fptr_t'(AF_LEVEL));
    end
  end

  // a flushed push must not land in storage
  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~clr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync.
// DEPTH=4, WIDTH=8, AF_LEVEL=3.
module tb_fifo_sync;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [2:0] count;
  logic       almost_full;

  int tests;
  int fails;

  fifo_sync_if #(.WIDTH(8)) bus ();

  fifo_sync #(
    .WIDTH    (8),
    .DEPTH    (4),
    .AF_LEVEL (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .bus         (bus),
    .count       (count),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".out_data"}, 32'(bus.out_data), 32'd0);
    chk({tag, ".af"}, 32'(almost_full), 32'd0);
  endtask

  logic [7:0] exp_q [4];

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #12;
    chk_idle("reset");
    rst = 1'b0;
    tick();
    tick();
    chk_idle("idle");

    // fill to full
    exp_q[0] = 8'h11;
    exp_q[1] = 8'h22;
    exp_q[2] = 8'h33;
    exp_q[3] = 8'h44;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = exp_q[i];
      tick();
      chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
      chk($sformatf("fill%0d.head", i), 32'(bus.out_data), 32'h11);
      chk($sformatf("fill%0d.af", i), 32'(almost_full),
          (i >= 2) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d.in_ready", i), 32'(bus.in_ready),
          (i == 3) ? 32'd0 : 32'd1);
    end
    bus.in_data = 8'h55;
    tick();
    tick();
    chk("held.count", 32'(count), 32'd4);
    chk("held.head", 32'(bus.out_data), 32'h11);
    chk("held.in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // drain
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d.valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("drain%0d.data", i), 32'(bus.out_data),
          32'(exp_q[i]));
      tick();
      chk($sformatf("drain%0d.count", i), 32'(count), 32'(3 - i));
    end
    chk("drained.valid", 32'(bus.out_valid), 32'd0);
    chk("drained.data", 32'(bus.out_data), 32'd0);
    chk("drained.af", 32'(almost_full), 32'd0);

    // streaming through four wraps
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 8'(i);
      if (i > 0) begin
        chk($sformatf("stream%0d.valid", i), 32'(bus.out_valid), 32'd1);
        chk($sformatf("stream%0d.data", i), 32'(bus.out_data),
            32'(i - 1));
      end
      tick();
      chk($sformatf("stream%0d.count", i), 32'(count), 32'd1);
    end
    bus.in_valid = 1'b0;
    chk("stream_last.data", 32'(bus.out_data), 32'h0F);
    tick();
    chk("stream_end.count", 32'(count), 32'd0);
    chk("stream_end.valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // clr beats a simultaneous push
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    tick();
    bus.in_data  = 8'h02;
    tick();
    chk("preclr.count", 32'(count), 32'd2);
    bus.in_data = 8'hAA;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    chk_idle("clr");
    tick();
    chk("clr_hold.valid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    tick();
    bus.in_valid = 1'b0;
    chk("postclr.data", 32'(bus.out_data), 32'h77);
    chk("postclr.count", 32'(count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("postclr_pop.valid", 32'(bus.out_valid), 32'd0);

    // async reset between edges
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    tick();
    bus.in_valid = 1'b0;
    chk("prerst.count", 32'(count), 32'd1);
    chk("prerst.data", 32'(bus.out_data), 32'h5A);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h6B;
    tick();
    bus.in_valid = 1'b0;
    chk("postrst.data", 32'(bus.out_data), 32'h6B);
    chk("postrst.count", 32'(count), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("postrst_pop.valid", 32'(bus.out_valid), 32'd0);
    chk("postrst_pop.count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Single-clock first-in first-out buffer built from flip-flop storage, with valid/ready handshakes on both sides.
- Decouples a producer stage from the register stage that consumes its data, absorbing bursts up to DEPTH words.
- Catalog element for pipelines that need buffering between flip-flop stages.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, number of storage entries; power of two, >=2.
- AF_LEVEL, DEPTH-1, occupancy at or above which almost_full asserts (1..DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- clr  input  1  synchronous flush; empties the FIFO on the next rising edge.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  FIFO can accept a word (not full).
- in_data  input  WIDTH  write data.
- out_valid  output  1  FIFO holds at least one word (not empty).
- out_ready  input  1  consumer takes the word on out_data.
- out_data  output  WIDTH  head-of-queue word (show-ahead).
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AF_LEVEL.

Behaviour:
- Reset (rst high, asynchronous): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=1, almost_full=0, out_data=0. Storage array is not reset.
- Pointers are $clog2(DEPTH)+1 bits. The MSB is a wrap bit.
  - empty: pointers are equal.
  - full: index bits are equal and wrap bits differ.
- push = in_valid & in_ready. Writes in_data to mem[wr_ptr index] on the rising edge, then increments wr_ptr.
- pop = out_valid & out_ready. Increments rd_ptr on the rising edge.
- Handshake outputs:
  - in_ready = !full.
  - out_valid = !empty.
  - Both are driven from registered pointer state only, never from in_valid or out_ready.
- out_data = mem[rd_ptr index] when out_valid, else 0. It is combinational from registered state and stays stable while out_valid=1 and out_ready=0.
- Latency: a word pushed at edge N appears on out_data with out_valid=1 after edge N, so it can be popped at edge N+1. There is no same-cycle fall-through when empty.
- Occupancy update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Full: in_ready=0, so no push is accepted even if a pop occurs in the same cycle. The next push is accepted in the cycle after the pop.
- Empty: out_valid=0, so out_ready is ignored and no underflow is possible.
- Wrap-around: the index wraps from DEPTH-1 to 0 and the wrap bit toggles. Ordering is preserved across any number of wraps.
- clr: on the edge where clr=1, rd_ptr=wr_ptr=0 and count=0.
  - clr overrides any simultaneous push or pop; the pushed word is discarded.
  - Outputs take their reset values after that edge.
- rst asserted mid-transfer: all state returns to reset values immediately; in-flight data is lost.
- almost_full is registered consistently with count: it is high exactly when count >= AF_LEVEL.
- The consumer may hold out_ready high permanently. The producer may hold in_valid high while in_ready=0; the word is held off until in_ready=1.

Decomposition:
- Shared package catalog_pkg:
  - Function or localparam for pointer width, $clog2(DEPTH)+1.
  - Typedef for pointer type parameterised by depth.
- Sub-module fifo_mem: DEPTH x WIDTH register array with one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr, rdata). No reset on the array.
- fifo_sync holds the pointers, count, flags and handshake logic, and instantiates fifo_mem.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=0, count=0, out_data=0, almost_full=0.
- Push 0x11,0x22,0x33,0x44 (DEPTH=4) with out_ready=0 -> count=4, in_ready=0, almost_full=1 from count=3. A fifth push of 0x55 is held off, and out_data=0x11 throughout.
- From full, out_ready=1 for 4 cycles -> out_data sequence 0x11,0x22,0x33,0x44, then out_valid=0, count=0.
- Continuous in_valid=out_ready=1 streaming 0x00..0x0F (16 words, 4 wraps) -> output order 0x00..0x0F with none lost or duplicated; count stays 1 after the first push.
- With count=2, assert clr together with push 0xAA -> next cycle count=0 and out_valid=0; 0xAA never appears on out_data.
- Push 0x5A, then pulse rst asynchronously between edges -> outputs return immediately to reset values; a subsequent push of 0x6B is the first word popped.
